// File: rtl/alu_seq_if.sv
// Purpose: bundles the request, response and ALU-side signals of the
//          byte-serial ALU sequencer into one interface.
// Ports:   slave = sequencer view; master = requester/ALU (environment) view.
interface alu_seq_if #(
  parameter int BYTES = 2
);
  localparam int W = 8 * BYTES;

  // requester -> sequencer
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;

  // sequencer -> consumer
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_ovf;

  // sequencer <-> ALU slice
  logic         alu_en;
  logic         alu_i3;
  logic         alu_i4;
  logic         alu_i5;
  logic         alu_c_in;
  logic [7:0]   alu_r;
  logic [7:0]   alu_s;
  logic [7:0]   alu_f;
  logic         alu_zero;
  logic         alu_c_out;
  logic         alu_overflow;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
           alu_f, alu_zero, alu_c_out, alu_overflow,
    output req_ready, rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_ovf,
           alu_en, alu_i3, alu_i4, alu_i5, alu_c_in, alu_r, alu_s
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
           alu_f, alu_zero, alu_c_out, alu_overflow,
    input  req_ready, rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_ovf,
           alu_en, alu_i3, alu_i4, alu_i5, alu_c_in, alu_r, alu_s
  );
endinterface

// File: rtl/alu_seq.sv
// Purpose: accepts a BYTES-wide op on a valid/ready request, runs it through an
//          8-bit ALU slice one byte per pass (LSB first, carry chained), and
//          returns the assembled result and flags on a valid/ready response.
// Latency: rsp_valid rises BYTES cycles after the accept edge (2*BYTES with
//          ALU_SEQ_SETTLE_EN defined: each byte gets a settle cycle before capture).
// Backpressure: req_ready is low outside IDLE; response is held stable in RESP
//          until rsp_ready.
// Ports:   clk, rst (async, active high); bus = alu_seq_if.slave carrying the
//          req_*, rsp_* and alu_* signals.
module alu_seq #(
  parameter int BYTES = 2
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;       // operands shift right one byte per pass
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_f;
  logic          r_carry;
  logic          r_zacc;
  logic          r_ovf;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_alu_en;
  logic          r_alu_c_in;
  logic [2:0]    r_alu_i;
  logic [7:0]    r_alu_r;
  logic [7:0]    r_alu_s;

  logic [W-1:0]  w_a_nxt;
  logic [W-1:0]  w_b_nxt;
  logic          w_last;
  logic          w_capture;

  assign w_a_nxt = r_a >> 8;
  assign w_b_nxt = r_b >> 8;
  assign w_last  = (r_idx == IW'(BYTES - 1));

`ifdef ALU_SEQ_SETTLE_EN
  // r_phase=0: settle cycle (operands driven, no capture); r_phase=1: capture.
  logic r_phase;
  assign w_capture = r_phase;
`else
  assign w_capture = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_f         <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_ovf       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_alu_en    <= 1'b0;
      r_alu_c_in  <= 1'b0;
      r_alu_i     <= '0;
      r_alu_r     <= '0;
      r_alu_s     <= '0;
`ifdef ALU_SEQ_SETTLE_EN
      r_phase     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            // Byte 0 is presented to the ALU in the very next cycle.
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_alu_r     <= bus.req_a[7:0];
            r_alu_s     <= bus.req_b[7:0];
            r_alu_c_in  <= bus.req_cin;
            r_alu_i     <= bus.req_op;
            r_zacc      <= 1'b1;
            r_idx       <= '0;
            r_alu_en    <= 1'b1;
            r_req_ready <= 1'b0;
`ifdef ALU_SEQ_SETTLE_EN
            r_phase     <= 1'b0;
`endif
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          if (w_capture) begin
            r_f[8*r_idx +: 8] <= bus.alu_f;
            r_carry           <= bus.alu_c_out;
            r_zacc            <= r_zacc & bus.alu_zero;
            r_ovf             <= bus.alu_overflow;
`ifdef ALU_SEQ_SETTLE_EN
            r_phase           <= 1'b0;
`endif
            if (w_last) begin
              // Release the bus and park the ALU drive at zero.
              r_alu_en    <= 1'b0;
              r_alu_r     <= '0;
              r_alu_s     <= '0;
              r_alu_c_in  <= 1'b0;
              r_alu_i     <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              // The registered c_in for the next byte is the carry-out just captured.
              r_idx      <= r_idx + 1'b1;
              r_a        <= w_a_nxt;
              r_b        <= w_b_nxt;
              r_alu_r    <= w_a_nxt[7:0];
              r_alu_s    <= w_b_nxt[7:0];
              r_alu_c_in <= bus.alu_c_out;
            end
          end else begin
`ifdef ALU_SEQ_SETTLE_EN
            r_phase <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_alu_en    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_f     = r_f;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_zero  = r_zacc;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.alu_en    = r_alu_en;
  assign bus.alu_i3    = r_alu_i[0];
  assign bus.alu_i4    = r_alu_i[1];
  assign bus.alu_i5    = r_alu_i[2];
  assign bus.alu_c_in  = r_alu_c_in;
  assign bus.alu_r     = r_alu_r;
  assign bus.alu_s     = r_alu_s;
endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: byte-wide ALU stub plus a whole-word reference model.
module tb_alu_seq;
  localparam int BYTES = 2;
  localparam int W     = 8 * BYTES;
`ifdef ALU_SEQ_SETTLE_EN
  localparam int CPB = 2;
`else
  localparam int CPB = 1;
`endif
  localparam int LAT = CPB * BYTES;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  alu_seq_if #(.BYTES(BYTES)) bus ();

  alu_seq #(.BYTES(BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU slice stub: op 000 = r+s+c_in, 001 = r^s, others r&s.
  logic [8:0] s9;
  logic [7:0] stub_f;
  logic       stub_co;
  logic       stub_ov;
  always_comb begin
    s9      = '0;
    stub_f  = '0;
    stub_co = 1'b0;
    stub_ov = 1'b0;
    case ({bus.alu_i5, bus.alu_i4, bus.alu_i3})
      3'b000: begin
        s9      = {1'b0, bus.alu_r} + {1'b0, bus.alu_s} + {8'd0, bus.alu_c_in};
        stub_f  = s9[7:0];
        stub_co = s9[8];
        stub_ov = (bus.alu_r[7] == bus.alu_s[7]) && (stub_f[7] != bus.alu_r[7]);
      end
      3'b001:  stub_f = bus.alu_r ^ bus.alu_s;
      default: stub_f = bus.alu_r & bus.alu_s;
    endcase
  end
  // While the bus is released it carries poison values, so any capture
  // outside alu_en corrupts the result visibly.
  assign bus.alu_f        = bus.alu_en ? stub_f : 8'hA5;
  assign bus.alu_zero     = bus.alu_en ? (stub_f == 8'h00) : 1'b0;
  assign bus.alu_c_out    = bus.alu_en ? stub_co : 1'b1;
  assign bus.alu_overflow = bus.alu_en ? stub_ov : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-word reference: the serial byte chain must equal one wide operation.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] f, output logic c,
                       output logic z, output logic v, output logic c1);
    logic [W:0] s;
    logic [8:0] lo;
    s  = '0;
    lo = '0;
    c  = 1'b0;
    v  = 1'b0;
    c1 = 1'b0;
    if (op == 3'b000) begin
      s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      f  = s[W-1:0];
      c  = s[W];
      v  = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
      lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
      c1 = lo[8];
    end else if (op == 3'b001) begin
      f = a ^ b;
    end else begin
      f = a & b;
    end
    z = (f == '0);
  endtask

  // Issue one op, check latency, ALU activity, byte-1 carry-in and the result;
  // optionally stall the response with a second request pending.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input int stall);
    logic [W-1:0] ef;
    logic ec, ez, ev, ec1;
    logic [W-1:0] held_f;
    int lat, en_cnt, guard;
    logic cin1, stable, rdy_low;
    model(op, a, b, cin, ef, ec, ez, ev, ec1);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk({tag, "_accept_timeout"}, 32'(guard < 50), 32'd1);
    step();
    bus.req_valid = 1'b0;
    lat    = 0;
    en_cnt = 0;
    cin1   = 1'b0;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.alu_en) en_cnt++;
      if (lat == CPB) cin1 = bus.alu_c_in;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_alu_en_cycles"}, 32'(en_cnt), 32'(LAT));
    chk({tag, "_byte1_cin"}, 32'(cin1), 32'(ec1));
    chk({tag, "_rsp_f"}, 32'(bus.rsp_f), 32'(ef));
    chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'(ec));
    chk({tag, "_zero"}, 32'(bus.rsp_zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(ev));
    chk({tag, "_alu_en_resp"}, 32'(bus.alu_en), 32'd0);
    held_f  = bus.rsp_f;
    stable  = 1'b1;
    rdy_low = 1'b1;
    if (stall > 0) begin
      bus.req_valid = 1'b1;
      bus.req_a     = W'($urandom);
      bus.req_b     = W'($urandom);
      for (int i = 0; i < stall; i++) begin
        step();
        if (!bus.rsp_valid || bus.rsp_f !== held_f || bus.rsp_carry !== ec ||
            bus.rsp_zero !== ez || bus.rsp_ovf !== ev) stable = 1'b0;
        if (bus.req_ready || bus.alu_en) rdy_low = 1'b0;
      end
      chk({tag, "_stall_stable"}, 32'(stable), 32'd1);
      chk({tag, "_stall_req_ready_low"}, 32'(rdy_low), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic saw_rsp;
    n_cmp  = 0;
    n_fail = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
    chk("rst_alu_drive", 32'({bus.alu_r, bus.alu_s, bus.alu_c_in, bus.alu_i5, bus.alu_i4, bus.alu_i3}), 32'd0);
    chk("rst_rsp_f", 32'(bus.rsp_f), 32'd0);
    chk("rst_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_ovf}), 32'd0);
    rst = 1'b0;
    step();

    run_op("add_carry_chain", 3'b000, 16'h00FF, 16'h0001, 1'b0, 0);
    run_op("add_wrap_zero",   3'b000, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("add_ovf",         3'b000, 16'h7F00, 16'h0100, 1'b0, 0);
    run_op("add_cin",         3'b000, 16'h12FF, 16'h3400, 1'b1, 0);
    run_op("stall_first",     3'b000, 16'h0F0F, 16'h0101, 1'b0, 5);
    run_op("stall_second",    3'b001, 16'hA5A5, 16'h5AA5, 1'b0, 0);

    // Reset during the byte-1 pass: bus released at once, no response.
    bus.req_op    = 3'b000;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h4321;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < CPB; i++) step();
    chk("midrst_alu_en_before", 32'(bus.alu_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_alu_en_async", 32'(bus.alu_en), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rsp_valid || bus.alu_en) saw_rsp = 1'b1;
    end
    chk("midrst_no_rsp", 32'(saw_rsp), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    run_op("after_rst", 3'b000, 16'h00FF, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      run_op("rand", 3'($urandom_range(0, 2)), W'($urandom), W'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
